pcint_ctrl: RTL
===============

# pcint_ctrl

Pin-change interrupt controller between the SoC's external GPIO input pins and the GPIO port / CPU interrupt logic. It synchronises and debounces each input pin and presents the cleaned level to the GPIO PINx read path. It latches masked level changes into write-1-to-clear pending flags and drives a single level interrupt request to the core. One instance is used per GPIO port (B and D).

## Interface
Parameters:
- WIDTH, 8: number of pins handled.
- SYNC_STAGES, 2: synchroniser flops per pin. Minimum 2.
- DEBOUNCE_CYCLES, 4: consecutive cycles a new synchronised level must hold before it is accepted. Minimum 1. Counter width is $clog2(DEBOUNCE_CYCLES+1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset. All flops clear immediately on assertion and are released synchronously by the clock.
- pin_in  in  WIDTH  raw asynchronous pad inputs.
- pin_clean  out  WIDTH  debounced pin levels, routed to the GPIO PINx read path.
- bus_sel  in  1  register access strobe, single cycle.
- bus_we  in  1  1 = write, 0 = read.
- bus_addr  in  2  register index.
- bus_wdata  in  WIDTH  write data.
- bus_rdata  out  WIDTH  read data. Combinational. Returns 0 when no read is in progress.
- irq  out  1  registered interrupt request, level-sensitive.

## Operation
- Register map:
  - 0 PCMSK: per-pin change enable, RW, reset 0.
  - 1 PCIFR: pending flags, read; writing 1 to a bit clears it, writing 0 has no effect; reset 0.
  - 2 PCICR: bit0 is the global enable, RW, reset 0; all other bits read 0.
  - 3 PINS: returns pin_clean, read-only; writes are ignored.
- Synchroniser: SYNC_STAGES flops per pin, all reset to 0. The last stage is called sync.
- Debounce, per pin:
  - State: a counter cnt and the accepted level deb, both reset to 0.
  - If sync == deb: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: deb <= sync and cnt <= 0.
  - Else: cnt <= cnt+1.
  - pin_clean = deb.
- Change detect: on any clock edge where a pin's deb toggles (either direction) and PCMSK for that pin is 1, PCIFR for that pin is set at that same edge.
  - A toggle on an unmasked pin never sets a flag, and is not remembered if the pin is masked later.
- Same-cycle set and clear on one flag bit: set wins, so the flag stays 1.
- PCMSK/PCIFR write and a deb toggle in the same cycle: the PCMSK value used is the one held before the write.
- irq <= PCICR[0] & (|PCIFR), registered.
  - Clearing the global enable drops irq on the next edge; pending flags are kept.
- Reset mid-operation: all flags, masks, counters and deb clear at once, and in-flight debounce counts are lost. After release, a pin held high produces a deb 0->1 toggle. It sets a flag only if software has already set that pin's mask bit.

## Timing
- Output values during reset: pin_clean = 0, irq = 0, bus_rdata = 0.
- A pin change that meets clock edge E0 appears at sync on edge E0+SYNC_STAGES-1.
- deb, pin_clean and PCIFR update at edge E0+SYNC_STAGES-1+DEBOUNCE_CYCLES. With defaults that is E0+5.
- irq rises one edge after the flag is set (defaults: E0+6).
- A write-1-to-clear at edge Ec clears the flag at Ec. irq falls at Ec+1 if no other flag is pending.
- Glitches are rejected if they last fewer than DEBOUNCE_CYCLES consecutive cycles at sync; any return to the deb level resets cnt.
- Register writes take effect at the edge where bus_sel & bus_we is sampled. Reads are zero-wait and combinational.

## Test plan
- Reset, defaults: hold rst_n=0 with pin_in=0xFF -> pin_clean=0, irq=0, every register reads 0. After release, pin_clean=0xFF at edge 5; PCIFR stays 0x00.
- Basic interrupt: PCMSK=0x01, PCICR=0x01, pin_in[0] 0->1 at E0 -> PCIFR=0x01 at E0+5 and irq=1 at E0+6. Write PCIFR=0x01 -> irq=0 one edge later.
- Glitch rejection: pin_in[3] high for 3 cycles with PCMSK=0x08 -> pin_clean[3] stays 0, PCIFR=0x00. Holding it high for 4 cycles -> PCIFR=0x08.
- Mask and enable gating: toggle pin 2 with PCMSK=0x00 -> no flag. With PCMSK=0x04 and PCICR=0 -> PCIFR=0x04 but irq=0; then set PCICR=1 -> irq=1 on the next edge.
- Set/clear collision: write PCIFR=0x02 in the same cycle that pin 1 is accepted -> PCIFR[1]=1 and irq remains 1.
- Mid-operation reset: assert rst_n while irq=1 and a debounce is in flight -> irq, PCIFR, PCMSK and pin_clean all read 0 immediately.

Source files
------------

// File: rtl/pcint_ctrl.sv
// pcint_ctrl: pin-change interrupt controller for one GPIO port.
// Synchronises and debounces each pad input, exposes the accepted levels,
// latches masked level changes into write-1-to-clear pending flags and
// drives a registered level interrupt request.
module pcint_ctrl #(
   parameter int WIDTH           = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] pin_in,
   output logic [WIDTH-1:0] pin_clean,
   input  logic             bus_sel,
   input  logic             bus_we,
   input  logic [1:0]       bus_addr,
   input  logic [WIDTH-1:0] bus_wdata,
   output logic [WIDTH-1:0] bus_rdata,
   output logic             irq
);

   localparam int                 CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

   localparam logic [1:0] ADDR_PCMSK = 2'd0;
   localparam logic [1:0] ADDR_PCIFR = 2'd1;
   localparam logic [1:0] ADDR_PCICR = 2'd2;
   localparam logic [1:0] ADDR_PINS  = 2'd3;

   // Synchroniser chain, stage 0 samples the pads
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
   logic [WIDTH-1:0]                  sync_last;

   // Debounce state
   logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]            deb_q, deb_d;
   logic [WIDTH-1:0]            toggle;

   // Software-visible registers and interrupt output
   logic [WIDTH-1:0] pcmsk_q, pcmsk_d;
   logic [WIDTH-1:0] pcifr_q, pcifr_d;
   logic [WIDTH-1:0] pcifr_clr;
   logic             pcicr_q, pcicr_d;
   logic             irq_q, irq_d;
   logic             wr_en;

   // Shift raw pad levels through the synchroniser chain
   always_comb begin
      sync_d[0] = pin_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
         sync_d[s] = sync_q[s-1];
      end
   end

   assign sync_last = sync_q[SYNC_STAGES-1];

   // Accept a new level only after it has held for DEBOUNCE_CYCLES samples;
   // any return to the accepted level restarts the count
   always_comb begin
      cnt_d = cnt_q;
      deb_d = deb_q;
      for (int i = 0; i < WIDTH; i++) begin
         if (sync_last[i] == deb_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            deb_d[i] = sync_last[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
         end
      end
   end

   assign toggle = deb_d ^ deb_q;

   // Register writes, flag latching and interrupt request. The flag set term
   // uses the mask held before any same-cycle write, and set beats clear.
   always_comb begin
      wr_en     = bus_sel & bus_we;
      pcmsk_d   = pcmsk_q;
      pcicr_d   = pcicr_q;
      pcifr_clr = '0;
      if (wr_en && (bus_addr == ADDR_PCMSK)) pcmsk_d   = bus_wdata;
      if (wr_en && (bus_addr == ADDR_PCIFR)) pcifr_clr = bus_wdata;
      if (wr_en && (bus_addr == ADDR_PCICR)) pcicr_d   = bus_wdata[0];
      pcifr_d = (pcifr_q & ~pcifr_clr) | (toggle & pcmsk_q);
      irq_d   = pcicr_q & (|pcifr_q);
   end

   // Zero-wait combinational read mux; idle or write cycles return 0
   always_comb begin
      bus_rdata = '0;
      if (bus_sel && !bus_we) begin
         case (bus_addr)
            ADDR_PCMSK: bus_rdata = pcmsk_q;
            ADDR_PCIFR: bus_rdata = pcifr_q;
            ADDR_PCICR: bus_rdata = WIDTH'(pcicr_q);
            ADDR_PINS:  bus_rdata = deb_q;
            default:    bus_rdata = '0;
         endcase
      end
   end

   // State registers, all cleared asynchronously by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         deb_q   <= '0;
         pcmsk_q <= '0;
         pcifr_q <= '0;
         pcicr_q <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         deb_q   <= deb_d;
         pcmsk_q <= pcmsk_d;
         pcifr_q <= pcifr_d;
         pcicr_q <= pcicr_d;
         irq_q   <= irq_d;
      end
   end

   assign pin_clean = deb_q;
   assign irq       = irq_q;

endmodule
